// File: rtl/abs_diff_sched.sv
// Round-robin scheduler sharing one |op1-op2| datapath among N_REQ requesters; ABS_DIFF_SCHED_PRIO0_EN gives requester 0 strict priority.
// Latency: response valid in the cycle after the third edge following the request handshake; one operation in flight.
// Backpressure: the response holds until rsp_ready; no request is accepted meanwhile.
module abs_diff_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_op1,
    input  logic [N_REQ*W-1:0] req_op2,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_res
);

    typedef enum logic [1:0] {IDLE, SUB, ABS, RESP} state_t;

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(N_REQ);

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   rsp_res_q, rsp_res_d;
    logic [W:0]     diff_q, diff_d;

    logic [N_REQ-1:0] rr_cand;
    logic [IDW-1:0]   grant;
    logic             grant_vld;
    logic [IDW:0]     sum;
    logic [IDW-1:0]   cand;

    // Rotating search from rr_ptr; with priority enabled requester 0 is taken first and excluded from the rotation.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        sum       = '0;
        cand      = '0;
        rr_cand   = req_valid;
`ifdef ABS_DIFF_SCHED_PRIO0_EN
        rr_cand   = {req_valid[N_REQ-1:1], 1'b0};
        if (req_valid[0]) begin
            grant_vld = 1'b1;
        end
`endif
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            cand = sum[IDW-1:0];
            if (!grant_vld && rr_cand[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        rsp_id_d  = rsp_id_q;
        rsp_res_d = rsp_res_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant] = ~rst;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant == IDW'(i)) begin
                            a_d = req_op1[i*W +: W];
                            b_d = req_op2[i*W +: W];
                        end
                    end
                    id_d = grant;
`ifdef ABS_DIFF_SCHED_PRIO0_EN
                    if (grant != '0)
`endif
                    rr_ptr_d = (grant == IDW'(N_REQ-1)) ? '0 : grant + IDW'(1);
                    state_d = SUB;
                end
            end
            SUB: begin
                diff_d  = {1'b0, a_q} - {1'b0, b_q};
                state_d = ABS;
            end
            ABS: begin
                // Negative difference is negated; the magnitude always fits in W bits.
                rsp_res_d = diff_q[W] ? (~diff_q[W-1:0] + W'(1)) : diff_q[W-1:0];
                rsp_id_d  = id_q;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            rsp_id_q  <= '0;
            rsp_res_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            diff_q    <= diff_d;
            rsp_id_q  <= rsp_id_d;
            rsp_res_q <= rsp_res_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;

endmodule

// File: tb/tb_abs_diff_sched.sv
// Randomized and directed bench for abs_diff_sched with a queue-based scoreboard and a behavioural arbitration model.
module tb_abs_diff_sched;
    localparam int N_REQ = 4;
    localparam int W     = 8;
    localparam int IDW   = 2;
`ifdef ABS_DIFF_SCHED_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_op1 = '0;
    logic [N_REQ*W-1:0] req_op2 = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [IDW-1:0]     rsp_id;
    logic [W-1:0]       rsp_res;

    abs_diff_sched #(.N_REQ(N_REQ), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_res(rsp_res)
    );

    always #5 clk = ~clk;

    typedef struct {int id; int res;} exp_t;
    exp_t             sb[$];
    int               grant_log[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               hs_cyc = 0;
    int               rr = 0;
    bit               busy = 1'b0;
    bit               seen = 1'b0;
    logic [N_REQ-1:0] hs_mask = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference arbitration: first valid requester at or after ptr, wrapping.
    function automatic int pick(input logic [N_REQ-1:0] v, input int ptr);
        if (PRIO0 && v[0]) return 0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (ptr + k) % N_REQ;
            if (PRIO0 && idx == 0) continue;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int rnd_op();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Monitor: model the expected grant every cycle, push expectations at handshake, check responses.
    always @(negedge clk) begin : mon
        int g;
        int act;
        int exp_rdy;
        cyc++;
        hs_mask = '0;
        if (rst) begin
            chk("req_ready_in_reset", int'(req_ready), 0);
            sb.delete();
            busy = 1'b0;
            seen = 1'b0;
            rr   = 0;
        end else begin
            g       = busy ? -1 : pick(req_valid, rr);
            exp_rdy = (g >= 0) ? (1 << g) : 0;
            chk("req_ready", int'(req_ready), exp_rdy);
            hs_mask = req_ready & req_valid;
            act = -1;
            for (int i = 0; i < N_REQ; i++)
                if (hs_mask[i] && act < 0) act = i;
            if (act >= 0) grant_log.push_back(act);
            if (g >= 0) begin
                sb.push_back('{id: g, res: absd(int'(req_op1[g*W +: W]), int'(req_op2[g*W +: W]))});
                hs_cyc = cyc;
                busy   = 1'b1;
                seen   = 1'b0;
                if (!(PRIO0 && g == 0)) rr = (g + 1) % N_REQ;
            end
            if (sb.size() > 0 && !seen && cyc - hs_cyc == 3)
                chk("rsp_valid_at_latency", int'(rsp_valid), 1);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp_valid", 1, 0);
                end else begin
                    if (!seen) chk("rsp_latency", cyc - hs_cyc, 3);
                    seen = 1'b1;
                    chk("sb_rsp_id", int'(rsp_id), sb[0].id);
                    chk("sb_rsp_res", int'(rsp_res), sb[0].res);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input int o1, input int o2);
        req_valid[i]       = v;
        req_op1[i*W +: W]  = W'(o1);
        req_op2[i*W +: W]  = W'(o2);
    endtask

    task automatic wait_hs(input int id);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!hs_mask[id] && n < 50);
        if (!hs_mask[id]) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || busy) chk("drain_timeout", 0, 1);
        tick();
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        req_valid = '1;
        tick();
        tick();
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_res", int'(rsp_res), 0);
        chk("reset_rsp_id", int'(rsp_id), 0);
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic do_op(input int id, input int o1, input int o2, input int exp);
        int n;
        rsp_ready = 1'b1;
        set_req(id, 1'b1, o1, o2);
        wait_hs(id);
        req_valid[id] = 1'b0;
        wait_rsp(n);
        chk("op_ticks_to_rsp", n, 2);
        chk("op_rsp_id", int'(rsp_id), id);
        chk("op_rsp_res", int'(rsp_res), exp);
        tick();
        chk("op_rsp_one_cycle", int'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int exp_order[$];
        int n;
        reset_dut();

        do_op(0, 123, 200, 77);
        do_op(2, 200, 123, 77);
        do_op(2, 0, 255, 255);
        do_op(2, 255, 0, 255);
        do_op(2, 90, 90, 0);

        // Grant order with every requester continuously valid.
`ifdef ABS_DIFF_SCHED_PRIO0_EN
        exp_order = '{0, 0, 0, 1, 2, 3, 1};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        reset_dut();
        rsp_ready = 1'b1;
        grant_log.delete();
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, i*40 + 3, 200 - i*30);
        n = 0;
        while (grant_log.size() < exp_order.size() && n < 200) begin
            tick();
            n++;
`ifdef ABS_DIFF_SCHED_PRIO0_EN
            if (grant_log.size() >= 3) req_valid[0] = 1'b0;
`endif
        end
        req_valid = '0;
        foreach (exp_order[k])
            chk("grant_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);
        drain();

        // Backpressure: response held while others wait.
        rsp_ready = 1'b0;
        set_req(3, 1'b1, 10, 250);
        wait_hs(3);
        req_valid[3] = 1'b0;
        set_req(0, 1'b1, 5, 6);
        set_req(1, 1'b1, 7, 9);
        wait_rsp(n);
        for (int k = 0; k < 5; k++) begin
            chk("stall_rsp_valid", int'(rsp_valid), 1);
            chk("stall_rsp_res", int'(rsp_res), 240);
            chk("stall_rsp_id", int'(rsp_id), 3);
            chk("stall_req_ready", int'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        chk("stall_release", int'(rsp_valid), 0);
        tick();

        // Reset while the operation sits in ABS.
        set_req(2, 1'b1, 50, 20);
        wait_hs(2);
        req_valid[2] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_rsp_valid", int'(rsp_valid), 0);
        chk("post_rst_rsp_res", int'(rsp_res), 0);
        chk("post_rst_rsp_id", int'(rsp_id), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("no_rsp_after_rst", int'(rsp_valid), 0);
        end
        grant_log.delete();
        set_req(1, 1'b1, 9, 4);
        set_req(3, 1'b1, 1, 2);
        n = 0;
        while (grant_log.size() < 1 && n < 20) begin
            tick();
            n++;
        end
        req_valid = '0;
        chk("first_grant_after_rst", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
        drain();

        // Randomized traffic with random response backpressure.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (hs_mask[i]) begin
                    set_req(i, 1'($urandom_range(0, 1)), rnd_op(), rnd_op());
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) set_req(i, 1'b1, rnd_op(), rnd_op());
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
